// File: rtl/wb_line_cache.sv
// Direct-mapped, write-back, write-allocate line cache between a 32-bit CPU
// Wishbone master and a 512-bit DDR2 Wishbone slave; every output is registered.
module wb_line_cache #(
    parameter int INDEX_BITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  s_addr,
    input  logic [31:0]  s_din,
    input  logic [3:0]   s_sel,
    input  logic         s_cyc,
    input  logic         s_stb,
    input  logic         s_we,
    output logic         s_ack,
    output logic [31:0]  s_dout,
    output logic [31:0]  m_addr,
    output logic [511:0] m_dout,
    output logic [63:0]  m_dm,
    output logic         m_cyc,
    output logic         m_stb,
    output logic         m_we,
    input  logic         m_ack,
    input  logic [511:0] m_din,
    output logic [2:0]   dbg_state
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 26 - INDEX_BITS;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACK  = 3'd1;
    localparam logic [2:0] ST_WB   = 3'd2;
    localparam logic [2:0] ST_FILL = 3'd3;

    logic [2:0]       state_q, state_d;
    logic             s_ack_q, s_ack_d;
    logic [31:0]      s_dout_q, s_dout_d;
    logic [31:0]      m_addr_q, m_addr_d;
    logic [511:0]     m_dout_q, m_dout_d;
    logic             m_we_q, m_we_d;
    logic             m_stb_q, m_stb_d;
    logic [25:0]      req_line_q, req_line_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;

    logic [511:0]     data_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];

    logic [INDEX_BITS-1:0] idx, req_idx, wr_idx;
    logic [TAG_W-1:0]      s_tag, req_tag;
    logic [3:0]            word;
    logic [511:0]          cur_line, merged_line, line_wdata;
    logic [31:0]           rd_word;
    logic                  hit, line_we, tag_we;

    assign idx      = s_addr[6 +: INDEX_BITS];
    assign s_tag    = s_addr[31 -: TAG_W];
    assign word     = s_addr[5:2];
    assign cur_line = data_q[idx];
    assign hit      = valid_q[idx] && (tag_q[idx] == s_tag);
    // The miss address is latched so the install still lands correctly if the CPU abandons the request.
    assign req_idx  = req_line_q[INDEX_BITS-1:0];
    assign req_tag  = req_line_q[25 -: TAG_W];

    always_comb begin
        rd_word     = 32'd0;
        merged_line = cur_line;
        for (int w = 0; w < 16; w++) begin
            if (word == 4'(w)) rd_word = cur_line[32*w +: 32];
        end
        for (int b = 0; b < 64; b++) begin
            if ((b / 4 == int'(word)) && s_sel[b[1:0]]) merged_line[8*b +: 8] = s_din[8*b[1:0] +: 8];
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        s_ack_d    = s_ack_q;
        s_dout_d   = s_dout_q;
        m_addr_d   = m_addr_q;
        m_dout_d   = m_dout_q;
        m_we_d     = m_we_q;
        m_stb_d    = m_stb_q;
        req_line_d = req_line_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        line_we    = 1'b0;
        tag_we     = 1'b0;
        wr_idx     = idx;
        line_wdata = merged_line;
        case (state_q)
            ST_IDLE: begin
                if (s_cyc && s_stb) begin
                    if (hit) begin
                        if (s_we) begin
                            line_we      = 1'b1;
                            dirty_d[idx] = 1'b1;
                        end else begin
                            s_dout_d = rd_word;
                        end
                        s_ack_d = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        req_line_d = s_addr[31:6];
                        m_stb_d    = 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            m_addr_d = {tag_q[idx], idx, 6'b0};
                            m_dout_d = cur_line;
                            m_we_d   = 1'b1;
                            state_d  = ST_WB;
                        end else begin
                            m_addr_d = {s_addr[31:6], 6'b0};
                            m_we_d   = 1'b0;
                            state_d  = ST_FILL;
                        end
                    end
                end
            end
            ST_ACK: begin
                s_ack_d = 1'b0;
                state_d = ST_IDLE;
            end
            ST_WB: begin
                if (m_ack) begin
                    m_addr_d = {req_line_q, 6'b0};
                    m_we_d   = 1'b0;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (m_ack) begin
                    line_we          = 1'b1;
                    tag_we           = 1'b1;
                    wr_idx           = req_idx;
                    line_wdata       = m_din;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    m_stb_d          = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_ack_q    <= 1'b0;
            s_dout_q   <= 32'd0;
            m_addr_q   <= 32'd0;
            m_dout_q   <= 512'd0;
            m_we_q     <= 1'b0;
            m_stb_q    <= 1'b0;
            req_line_q <= 26'd0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            s_ack_q    <= s_ack_d;
            s_dout_q   <= s_dout_d;
            m_addr_q   <= m_addr_d;
            m_dout_q   <= m_dout_d;
            m_we_q     <= m_we_d;
            m_stb_q    <= m_stb_d;
            req_line_q <= req_line_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
        end
    end

    // NOTE: line data and tags are left unreset; the valid bits alone make their contents meaningful.
    always_ff @(posedge clk) begin
        if (line_we) data_q[wr_idx] <= line_wdata;
        if (tag_we)  tag_q[wr_idx]  <= req_tag;
    end

    assign s_ack     = s_ack_q;
    assign s_dout    = s_dout_q;
    assign m_addr    = m_addr_q;
    assign m_dout    = m_dout_q;
    assign m_dm      = '1;
    assign m_cyc     = m_stb_q;
    assign m_stb     = m_stb_q;
    assign m_we      = m_we_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_line_cache.sv
// Bench for wb_line_cache: directed and random CPU traffic against a flat-memory
// reference model, with a DDR slave model that logs every line transfer.
module tb_wb_line_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_addr, s_din;
    logic [3:0]   s_sel;
    logic         s_cyc, s_stb, s_we;
    logic         s_ack;
    logic [31:0]  s_dout;
    logic [31:0]  m_addr;
    logic [511:0] m_dout;
    logic [63:0]  m_dm;
    logic         m_cyc, m_stb, m_we;
    logic         m_ack;
    logic [511:0] m_din;
    logic [2:0]   dbg_state;

    wb_line_cache #(.INDEX_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .s_addr(s_addr), .s_din(s_din), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_ack(s_ack), .s_dout(s_dout),
        .m_addr(m_addr), .m_dout(m_dout), .m_dm(m_dm),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_ack(m_ack), .m_din(m_din), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ack_edge = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [511:0] data;
    } ddr_txn_t;

    ddr_txn_t     log_q[$];
    logic [511:0] ddr_mem [logic [25:0]];
    logic [31:0]  model_mem [logic [29:0]];
    logic         c_valid [4];
    logic         c_dirty [4];
    logic [25:0]  c_line [4];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_init(input logic [29:0] wa);
        return (32'(wa) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [511:0] ddr_line(input logic [25:0] la);
        logic [511:0] l;
        if (ddr_mem.exists(la)) return ddr_mem[la];
        for (int w = 0; w < 16; w++) l[32*w +: 32] = word_init({la, 4'(w)});
        return l;
    endfunction

    function automatic logic [31:0] model_word(input logic [29:0] wa);
        if (model_mem.exists(wa)) return model_mem[wa];
        return word_init(wa);
    endfunction

    function automatic logic [511:0] model_line(input logic [25:0] la);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[32*w +: 32] = model_word({la, 4'(w)});
        return l;
    endfunction

    // DDR slave: acts on strobes seen at the falling edge, acks after a random delay,
    // and re-samples the strobe on the cycle right after each ack.
    initial begin : ddr_model
        logic        busy, post_rd, post_wr, t_we;
        logic [31:0] t_addr;
        int          wait_n;
        busy = 0; post_rd = 0; post_wr = 0; t_we = 0; t_addr = 0; wait_n = 0;
        m_ack = 1'b0;
        m_din = '0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (rst) begin
                busy = 0; post_rd = 0; post_wr = 0;
                continue;
            end
            if (m_cyc !== m_stb) check("cyc_eq_stb", m_cyc, m_stb);
            if (post_rd) check("stb_low_after_fill", m_stb, 1'b0);
            if (post_wr) check("wb_to_fill_stb_we", {m_stb, m_we}, 2'b10);
            post_rd = 0; post_wr = 0;
            if (busy) begin
                check("m_req_stable", {m_we, m_addr}, {t_we, t_addr});
                if (wait_n > 0) begin
                    wait_n--;
                end else begin
                    m_ack = 1'b1;
                    if (t_we) begin
                        check("m_dm_all_ones", m_dm, 64'hFFFF_FFFF_FFFF_FFFF);
                        ddr_mem[t_addr[31:6]] = m_dout;
                        log_q.push_back('{we: 1'b1, addr: t_addr, data: m_dout});
                        post_wr = 1;
                    end else begin
                        m_din = ddr_line(t_addr[31:6]);
                        log_q.push_back('{we: 1'b0, addr: t_addr, data: m_din});
                        post_rd = 1;
                    end
                    last_ack_edge = cyc + 1;
                    busy = 0;
                end
            end else if (m_stb) begin
                busy   = 1;
                t_addr = m_addr;
                t_we   = m_we;
                wait_n = $urandom_range(0, 3);
                check("m_addr_line_aligned", m_addr[5:0], 6'd0);
            end
        end
    end

    // One CPU access, started and finished on a falling edge, predicted and checked against the model.
    task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] din, input logic [3:0] sel);
        logic [1:0]   i;
        logic [25:0]  la, victim;
        logic [511:0] victim_data;
        logic [31:0]  exp_word, rdata;
        logic         exp_hit, exp_evict, got;
        int           e0, ack_edge;
        i           = addr[7:6];
        la          = addr[31:6];
        exp_hit     = c_valid[i] && (c_line[i] == la);
        exp_evict   = !exp_hit && c_valid[i] && c_dirty[i];
        victim      = c_line[i];
        victim_data = model_line(victim);
        exp_word    = model_word(addr[31:2]);
        log_q.delete();
        s_addr = addr; s_we = we; s_din = din; s_sel = sel;
        s_cyc  = 1'b1; s_stb = 1'b1;
        e0  = cyc + 1;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = s_ack;
        end
        check("s_ack_seen", got, 1'b1);
        ack_edge = cyc;
        rdata    = s_dout;
        check("state_ack", dbg_state, 3'd1);
        s_cyc = 1'b0; s_stb = 1'b0;
        @(negedge clk);
        check("s_ack_single_pulse", s_ack, 1'b0);
        if (exp_hit) begin
            check("hit_latency", 32'(ack_edge - e0 + 1), 32'd1);
            check("hit_no_ddr", 32'(log_q.size()), 32'd0);
        end else begin
            check("miss_ddr_count", 32'(log_q.size()), exp_evict ? 32'd2 : 32'd1);
            if (exp_evict && log_q.size() == 2) begin
                check("evict_is_write", log_q[0].we, 1'b1);
                check("evict_addr", log_q[0].addr, {victim, 6'b0});
                check("evict_data", log_q[0].data, victim_data);
            end
            if (log_q.size() > 0) begin
                check("fill_is_read", log_q[log_q.size()-1].we, 1'b0);
                check("fill_addr", log_q[log_q.size()-1].addr, {la, 6'b0});
                if (!we) check("fill_word", rdata, log_q[log_q.size()-1].data[32*addr[5:2] +: 32]);
            end
            check("miss_ack_edge", 32'(ack_edge), 32'(last_ack_edge + 1));
        end
        if (!we) begin
            check("read_data", rdata, exp_word);
        end else begin
            for (int b = 0; b < 4; b++) if (sel[b]) exp_word[8*b +: 8] = din[8*b +: 8];
            model_mem[addr[31:2]] = exp_word;
        end
        c_dirty[i] = exp_hit ? (c_dirty[i] | we) : we;
        c_valid[i] = 1'b1;
        c_line[i]  = la;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        logic [31:0] a;
        logic        seen;
        for (int k = 0; k < 4; k++) begin c_valid[k] = 0; c_dirty[k] = 0; c_line[k] = 0; end
        rst = 1'b1;
        s_addr = 0; s_din = 0; s_sel = 0; s_cyc = 0; s_stb = 0; s_we = 0;
        repeat (2) @(negedge clk);
        check("rst_s_ack", s_ack, 1'b0);
        check("rst_s_dout", s_dout, 32'd0);
        check("rst_m_ctrl", {m_cyc, m_stb, m_we}, 3'b000);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_state", dbg_state, 3'd0);
        check("rst_m_dm", m_dm, 64'hFFFF_FFFF_FFFF_FFFF);
        rst = 1'b0;
        @(negedge clk);

        access(32'h0000_0104, 1'b0, 32'd0, 4'h0);          // clean read miss
        access(32'h0000_0104, 1'b1, 32'hDEAD_BEEF, 4'b0101); // write hit
        access(32'h0000_0104, 1'b0, 32'd0, 4'h0);          // merged read hit
        access(32'h0000_1100, 1'b0, 32'd0, 4'h0);          // dirty eviction of 0x100
        access(32'h0000_0104, 1'b0, 32'd0, 4'h0);          // refetch after write-back

        // Reset while the write-back of a dirty line is outstanding.
        access(32'h0000_1108, 1'b1, 32'h1234_5678, 4'hF);
        s_addr = 32'h0000_0100; s_we = 1'b0; s_sel = 4'h0; s_din = 0;
        s_cyc = 1'b1; s_stb = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = m_stb;
        end
        check("wb_stb_seen", {seen, m_we}, 2'b11);
        rst = 1'b1;
        s_cyc = 1'b0; s_stb = 1'b0;
        #1;
        check("rst_mid_m_stb", m_stb, 1'b0);
        check("rst_mid_s_ack", s_ack, 1'b0);
        check("rst_mid_state", dbg_state, 3'd0);
        for (int k = 0; k < 4; k++) begin
            if (c_valid[k] && c_dirty[k])
                for (int w = 0; w < 16; w++)
                    model_mem[{c_line[k], 4'(w)}] = ddr_line(c_line[k])[32*w +: 32];
            c_valid[k] = 0; c_dirty[k] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(32'h0000_1108, 1'b0, 32'd0, 4'h0);          // must miss and see pre-write data

        for (int n = 0; n < 200; n++) begin
            a = {22'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
            if ($urandom_range(0, 1) == 1)
                access(a, 1'b1, $urandom, 4'($urandom));
            else
                access(a, 1'b0, 32'd0, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
